// File: rtl/freq_meter_pkg.sv
// ---------------------------------------------------------------------------
// freq_meter_pkg
//
// Purpose:
//   Shared types and constants for the PLL output frequency meter
//   (clk_freq_meter) and its input synchronizer (sync_edge_det).
//
// Contents:
//   state_t      - measurement FSM states (IDLE, ARM, MEASURE)
//   SYNC_STAGES  - number of synchronizer flops ahead of the edge detector
//   ARM_CYCLES   - cycles spent in ARM while the synchronizer is flushed
//   sat_inc      - saturating increment helper
// ---------------------------------------------------------------------------
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int ARM_CYCLES  = 3;

  // Adds inc to val but never exceeds max_val. The caller passes values
  // zero-extended to 32 bits and narrows the result back to its own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input logic [31:0] max_val);
    if (inc && (val < max_val)) begin
      return val + 32'd1;
    end
    return val;
  endfunction

endpackage : freq_meter_pkg

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//
// Purpose:
//   Brings an asynchronous square wave into the clk domain through a
//   SYNC_STAGES-deep flop chain, keeps one more flop of history and flags
//   rising edges of the synchronized signal. With SYNC_STAGES=2 a transition
//   on async_in is reported by edge_out during the cycle that follows the
//   second clk edge after it.
//
// Ports:
//   clk      in   reference clock
//   rst_n    in   asynchronous active-low reset (all flops clear to 0)
//   async_in in   asynchronous input
//   edge_out out  one-cycle pulse for each synchronized rising edge
// ---------------------------------------------------------------------------
module sync_edge_det
  import freq_meter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule : sync_edge_det

// File: rtl/clk_freq_meter.sv
// ---------------------------------------------------------------------------
// clk_freq_meter
//
// Purpose:
//   Frequency monitor for PLL outputs, running on the 27 MHz reference.
//   Counts rising edges of a slow square wave (derived from the PLL output)
//   over back-to-back gate windows of GATE_CYCLES clk cycles, reports each
//   count, and asserts clk_ok once GOOD_WINDOWS consecutive windows fall in
//   [EXP_MIN, EXP_MAX].
//
// Parameters:
//   GATE_CYCLES  - gate window length in clk cycles
//   CNT_W        - width of the edge counter and of count
//   EXP_MIN      - smallest in-range count (inclusive)
//   EXP_MAX      - largest in-range count (inclusive)
//   GOOD_WINDOWS - consecutive in-range windows needed for clk_ok
//
// Ports:
//   clk          in   27 MHz reference clock
//   rst_n        in   asynchronous active-low reset
//   en           in   measurement enable (level)
//   meas_tgl     in   asynchronous square wave under test (<= clk/4)
//   count        out  edge count of the last completed window
//   count_valid  out  one-cycle pulse when count updates
//   in_range     out  last completed window was within [EXP_MIN, EXP_MAX]
//   clk_ok       out  frequency confirmed stable
//   err_sticky   out  loss-of-lock latch (0 unless the macro below is set)
//   err_clr      in   clears err_sticky
//
// Build option:
//   FREQ_METER_STICKY_ERR_EN - when defined, err_sticky latches whenever
//   clk_ok drops because of a bad window and holds until err_clr. When not
//   defined, err_sticky is a constant 0 and err_clr is ignored.
// ---------------------------------------------------------------------------
module clk_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES  = 27000,
  parameter int CNT_W        = 16,
  parameter int EXP_MIN      = 1100,
  parameter int EXP_MAX      = 1150,
  parameter int GOOD_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             meas_tgl,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             clk_ok,
  output logic             err_sticky,
  input  logic             err_clr
);

  localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
  localparam int ARM_W  = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [ARM_W-1:0]  ARM_LAST  = ARM_W'(ARM_CYCLES - 1);
  localparam logic [GOOD_W-1:0] GOOD_FULL = GOOD_W'(GOOD_WINDOWS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [31:0]       EXP_MIN_U = 32'(EXP_MIN);
  localparam logic [31:0]       EXP_MAX_U = 32'(EXP_MAX);
  localparam logic [31:0]       CNT_MAX_U = 32'(CNT_MAX);

  // A saturated count may hide an arbitrarily fast clock, so it is only
  // accepted when the upper limit itself sits at the saturation value.
  localparam bit SAT_ACCEPTABLE = (EXP_MAX_U == CNT_MAX_U);

  state_t             state_q, state_d;
  logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               count_valid_q, count_valid_d;
  logic               in_range_q, in_range_d;
  logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
  logic               clk_ok_q, clk_ok_d;

  logic               edge_now;
  logic [CNT_W-1:0]   edge_sum;
  logic               sum_saturated;
  logic               window_in_range;
  logic               bad_window;

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (meas_tgl),
    .edge_out (edge_now)
  );

  // Running count including the current cycle's edge; on the terminal gate
  // cycle this is the final window count, so a terminal-cycle edge belongs
  // to the closing window.
  assign edge_sum        = CNT_W'(sat_inc(32'(edge_cnt_q), edge_now, CNT_MAX_U));
  assign sum_saturated   = (edge_sum == CNT_MAX);
  assign window_in_range = (32'(edge_sum) >= EXP_MIN_U) &&
                           (32'(edge_sum) <= EXP_MAX_U) &&
                           (!sum_saturated || SAT_ACCEPTABLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      arm_cnt_q     <= '0;
      gate_cnt_q    <= '0;
      edge_cnt_q    <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      in_range_q    <= 1'b0;
      good_cnt_q    <= '0;
      clk_ok_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      arm_cnt_q     <= arm_cnt_d;
      gate_cnt_q    <= gate_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      in_range_q    <= in_range_d;
      good_cnt_q    <= good_cnt_d;
      clk_ok_q      <= clk_ok_d;
    end
  end

  // Dropping en takes priority over everything, including a terminal gate
  // cycle: the window is thrown away, good_cnt restarts and count/in_range
  // keep the last reported result.
  always_comb begin
    state_d       = state_q;
    arm_cnt_d     = arm_cnt_q;
    gate_cnt_d    = gate_cnt_q;
    edge_cnt_d    = edge_cnt_q;
    count_d       = count_q;
    count_valid_d = 1'b0;
    in_range_d    = in_range_q;
    good_cnt_d    = good_cnt_q;
    bad_window    = 1'b0;

    if (!en) begin
      state_d    = IDLE;
      arm_cnt_d  = '0;
      gate_cnt_d = '0;
      edge_cnt_d = '0;
      good_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = ARM;
          arm_cnt_d = '0;
        end

        // Edges seen here are stale synchronizer contents and are dropped.
        ARM: begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d    = MEASURE;
            arm_cnt_d  = '0;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
          end else begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
          end
        end

        MEASURE: begin
          if (gate_cnt_q == GATE_LAST) begin
            count_d       = edge_sum;
            count_valid_d = 1'b1;
            in_range_d    = window_in_range;
            gate_cnt_d    = '0;
            edge_cnt_d    = '0;
            if (window_in_range) begin
              if (good_cnt_q != GOOD_FULL) begin
                good_cnt_d = good_cnt_q + GOOD_W'(1);
              end
            end else begin
              good_cnt_d = '0;
              bad_window = 1'b1;
            end
          end else begin
            gate_cnt_d = gate_cnt_q + GATE_W'(1);
            edge_cnt_d = edge_sum;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    clk_ok_d = (good_cnt_d == GOOD_FULL);
  end

  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign in_range    = in_range_q;
  assign clk_ok      = clk_ok_q;

`ifdef FREQ_METER_STICKY_ERR_EN
  logic err_q;

  // Only a bad window that knocks clk_ok down counts as loss of lock; a set
  // in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bad_window && clk_ok_q) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err_sticky = err_q;
`else
  logic [1:0] unused_err_inputs;

  assign unused_err_inputs = {err_clr, bad_window};
  assign err_sticky        = 1'b0;
`endif

endmodule : clk_freq_meter

// File: tb/tb_clk_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_freq_meter
//
// Directed bench for clk_freq_meter. Three instances:
//   u_dut  - scaled main build: GATE_CYCLES=1200, window [49,51], so a
//            24-cycle meas_tgl period gives 50 edges and a 20-cycle period 60
//   u_term - GATE_CYCLES=16, for the terminal-cycle edge case
//   u_sat  - CNT_W=4, GATE_CYCLES=64, for saturation (16 edges -> 15)
// ---------------------------------------------------------------------------
module tb_clk_freq_meter;

  localparam int GATE      = 1200;
  localparam int ARM_CYC   = 3;
  localparam int NOM_CNT   = 50;
  localparam int FAST_CNT  = 60;

`ifdef FREQ_METER_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // main instance signals
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic        meas_tgl = 1'b0;
  logic        err_clr  = 1'b0;
  logic [15:0] count;
  logic        count_valid, in_range, clk_ok, err_sticky;

  // terminal-edge instance signals
  logic        en_t   = 1'b0;
  logic        meas_t = 1'b0;
  logic [15:0] count_t;
  logic        count_valid_t, in_range_t, clk_ok_t, err_sticky_t;

  // saturation instance signals
  logic        en_s   = 1'b0;
  logic        meas_s = 1'b0;
  logic [3:0]  count_s;
  logic        count_valid_s, in_range_s, clk_ok_s, err_sticky_s;

  // meas_tgl generator: toggles every half_period clk cycles on the falling edge
  int half_period = 12;
  bit gen_on      = 1'b0;
  int ph          = 0;
  always @(negedge clk) begin
    if (gen_on) begin
      ph = ph + 1;
      if (ph >= half_period) begin
        ph       = 0;
        meas_tgl = ~meas_tgl;
      end
    end
  end

  // period-4 generator for the saturation instance
  bit gen_s  = 1'b0;
  bit ph_s   = 1'b0;
  always @(negedge clk) begin
    if (gen_s) begin
      ph_s = ~ph_s;
      if (ph_s) meas_s = ~meas_s;
    end
  end

  clk_freq_meter #(
    .GATE_CYCLES(GATE), .CNT_W(16), .EXP_MIN(49), .EXP_MAX(51), .GOOD_WINDOWS(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .meas_tgl(meas_tgl),
    .count(count), .count_valid(count_valid), .in_range(in_range),
    .clk_ok(clk_ok), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  clk_freq_meter #(
    .GATE_CYCLES(16), .CNT_W(16), .EXP_MIN(1), .EXP_MAX(2), .GOOD_WINDOWS(4)
  ) u_term (
    .clk(clk), .rst_n(rst_n), .en(en_t), .meas_tgl(meas_t),
    .count(count_t), .count_valid(count_valid_t), .in_range(in_range_t),
    .clk_ok(clk_ok_t), .err_sticky(err_sticky_t), .err_clr(1'b0)
  );

  clk_freq_meter #(
    .GATE_CYCLES(64), .CNT_W(4), .EXP_MIN(1), .EXP_MAX(10), .GOOD_WINDOWS(4)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en_s), .meas_tgl(meas_s),
    .count(count_s), .count_valid(count_valid_s), .in_range(in_range_s),
    .clk_ok(clk_ok_s), .err_sticky(err_sticky_s), .err_clr(1'b0)
  );

  // Waits (bounded) for the main instance's next count_valid; samples #1
  // after each rising edge. cyc counts rising edges waited.
  task automatic wait_cv(input int max_cyc, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
      if (count_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit got;
    int cyc;
    rst_n = 1'b0; en = 1'b1; err_clr = 1'b0; half_period = 12; gen_on = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (count !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count);
    end
    checks++;
    if ({count_valid, in_range, clk_ok, err_sticky} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got cv/ir/ok/err=%b expected 0000",
               {count_valid, in_range, clk_ok, err_sticky});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_cv(GATE + 100, got, cyc);
    // first enabled edge moves to ARM; count_valid follows ARM + GATE cycles later
    checks++;
    if (!got || cyc != GATE + ARM_CYC + 1) begin
      errors++;
      $display("[TB] FAIL first_latency: got %0d cycles (seen=%0d) expected %0d",
               cyc, got, GATE + ARM_CYC + 1);
    end
    checks++;
    if (count !== 16'(NOM_CNT) || in_range !== 1'b1 || clk_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL first_window: got count=%0d ir=%b ok=%b expected count=%0d ir=1 ok=0",
               count, in_range, clk_ok, NOM_CNT);
    end
  endtask

  task automatic test_nominal();
    bit got;
    int cyc;
    for (int w = 2; w <= 4; w++) begin
      wait_cv(GATE + 10, got, cyc);
      checks++;
      if (!got || cyc != GATE) begin
        errors++;
        $display("[TB] FAIL nom_spacing w%0d: got %0d cycles (seen=%0d) expected %0d",
                 w, cyc, got, GATE);
      end
      checks++;
      if (count !== 16'(NOM_CNT) || in_range !== 1'b1 || clk_ok !== (w == 4)) begin
        errors++;
        $display("[TB] FAIL nom_window w%0d: got count=%0d ir=%b ok=%b expected count=%0d ir=1 ok=%0d",
                 w, count, in_range, clk_ok, NOM_CNT, (w == 4));
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (count_valid !== 1'b0 || clk_ok !== 1'b1 || err_sticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL nom_after: got cv=%b ok=%b err=%b expected cv=0 ok=1 err=0",
               count_valid, clk_ok, err_sticky);
    end
  endtask

  task automatic test_reset_mid_window();
    bit got;
    int cyc;
    repeat (400) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 16'd0 || {count_valid, in_range, clk_ok, err_sticky} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got count=%0d cv/ir/ok/err=%b expected 0 and 0000",
               count, {count_valid, in_range, clk_ok, err_sticky});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      wait_cv(GATE + 100, got, cyc);
      if (w == 1) begin
        checks++;
        if (!got || cyc != GATE + ARM_CYC + 1) begin
          errors++;
          $display("[TB] FAIL midreset_latency: got %0d cycles (seen=%0d) expected %0d",
                   cyc, got, GATE + ARM_CYC + 1);
        end
      end
    end
    checks++;
    if (clk_ok !== 1'b1 || count !== 16'(NOM_CNT)) begin
      errors++;
      $display("[TB] FAIL midreset_relock: got ok=%b count=%0d expected ok=1 count=%0d",
               clk_ok, count, NOM_CNT);
    end
  endtask

  task automatic test_fast();
    bit got;
    int cyc;
    half_period = 10;
    wait_cv(GATE + 10, got, cyc);
    // this window straddles the period switch, so only a band is certain
    checks++;
    if (!got || count < 16'd58 || count > 16'd61 || in_range !== 1'b0 ||
        clk_ok !== 1'b0 || err_sticky !== STICKY) begin
      errors++;
      $display("[TB] FAIL fast_first: got seen=%0d count=%0d ir=%b ok=%b err=%b expected count 58..61 ir=0 ok=0 err=%0d",
               got, count, in_range, clk_ok, err_sticky, STICKY);
    end
    wait_cv(GATE + 10, got, cyc);
    checks++;
    if (!got || count !== 16'(FAST_CNT) || in_range !== 1'b0 || clk_ok !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fast_second: got seen=%0d count=%0d ir=%b ok=%b expected count=%0d ir=0 ok=0",
               got, count, in_range, clk_ok, FAST_CNT);
    end
    checks++;
    if (err_sticky !== STICKY) begin
      errors++;
      $display("[TB] FAIL err_held: got %b expected %0d", err_sticky, STICKY);
    end
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++; $display("[TB] FAIL err_clear: got %b expected 0", err_sticky);
    end
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_abort();
    bit got;
    bit seen;
    int cyc;
    half_period = 12;
    seen = 1'b0;
    for (int w = 0; w < 8 && !seen; w++) begin
      wait_cv(GATE + 10, got, cyc);
      if (got && clk_ok === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || count !== 16'(NOM_CNT)) begin
      errors++;
      $display("[TB] FAIL abort_relock: got ok_seen=%0d count=%0d expected 1 and %0d",
               seen, count, NOM_CNT);
    end
    // count_valid cycle is gate cycle 0; advance to gate cycle 1000
    repeat (1000) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (clk_ok !== 1'b0 || count_valid !== 1'b0 || count !== 16'(NOM_CNT) ||
        in_range !== 1'b1 || err_sticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_next: got ok=%b cv=%b count=%0d ir=%b err=%b expected ok=0 cv=0 count=%0d ir=1 err=0",
               clk_ok, count_valid, count, in_range, err_sticky, NOM_CNT);
    end
    seen = 1'b0;
    repeat (GATE + 300) begin
      @(posedge clk);
      #1;
      if (count_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || count !== 16'(NOM_CNT)) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got cv_seen=%0d count=%0d expected 0 and %0d",
               seen, count, NOM_CNT);
    end
  endtask

  task automatic test_terminal_edge();
    @(negedge clk);
    en_t = 1'b1;
    // P1 enters ARM, P4 enters MEASURE, gate cycle 15 follows P19
    repeat (17) @(posedge clk);
    @(negedge clk);
    meas_t = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (count_valid_t !== 1'b1 || count_t !== 16'd1) begin
      errors++;
      $display("[TB] FAIL term_edge: got cv=%b count=%0d expected cv=1 count=1",
               count_valid_t, count_t);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    meas_t = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    meas_t = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (count_valid_t !== 1'b1 || count_t !== 16'd1) begin
      errors++;
      $display("[TB] FAIL term_next: got cv=%b count=%0d expected cv=1 count=1",
               count_valid_t, count_t);
    end
    en_t = 1'b0;
  endtask

  task automatic test_saturation();
    bit got;
    int cyc;
    @(negedge clk);
    gen_s = 1'b1;
    en_s  = 1'b1;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (count_valid_s === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || count_s !== 4'hF || in_range_s !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_count: got seen=%0d count=%0d ir=%b expected count=15 ir=0",
               got, count_s, in_range_s);
    end
    en_s  = 1'b0;
    gen_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_reset_mid_window();
    test_fast();
    test_abort();
    test_terminal_edge();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_clk_freq_meter
